motor_ramp_ctrl: RTL and testbench

Soft-start and direction sequencer for one rover drive channel. Accepts target duty/direction commands over a valid/ready handshake and slews the duty fed to the PWM generator by at most STEP counts per PWM period. Duty updates happen only on the generator's end-of-period pulse, so no period is ever truncated. Direction reversals are forced through zero duty plus a dead interval, and an estop input kills drive immediately.

---
 rtl/motor_ramp_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: soft-start and direction sequencer for one drive channel.
// Slews PWM duty per period, forces reversals through zero plus dead time.
module motor_ramp_ctrl #(
    parameter int SIZE         = 12,
    parameter int PERIOD       = 4000,
    parameter int STEP         = 40,
    parameter int DEAD_PERIODS = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [SIZE-1:0] cmd_duty,
    input  logic            cmd_dir,
    input  logic            estop,
    input  logic            pwm_done,
    output logic [SIZE-1:0] duty,
    output logic            dir,
    output logic            busy,
    output logic            at_target
);

    localparam int CW = (DEAD_PERIODS < 1) ? 1 : $clog2(DEAD_PERIODS + 1);

    localparam logic [SIZE-1:0] DUTY_MAX = SIZE'(PERIOD);
    localparam logic [SIZE:0]   STEP_W   = (SIZE+1)'(STEP);
    localparam logic [SIZE-1:0] STEP_N   = SIZE'(STEP);
    localparam logic [CW:0]     DEAD_W   = (CW+1)'(DEAD_PERIODS);

    typedef enum logic [2:0] {
        IDLE,
        RAMP,
        HOLD,
        REV_DOWN,
        DEAD,
        ESTOP
    } state_t;

    state_t          state;
    logic [SIZE-1:0] target;
    logic [SIZE-1:0] pend_target;
    logic            pend_dir;
    logic [CW-1:0]   dead_cnt;

    logic [SIZE-1:0] cmd_clamp;
    logic [SIZE:0]   up_sum;
    logic [SIZE:0]   dn_gap;
    logic [SIZE-1:0] slew;
    logic [SIZE-1:0] duty_nx;
    logic            slewing;
    logic            accept;
    logic            same_dir;
    logic            dead_last;

    // Requested duty limited to one full PWM period
    always_comb begin
        cmd_clamp = cmd_duty;
        if (cmd_duty > DUTY_MAX) begin
            cmd_clamp = DUTY_MAX;
        end
    end

    // One rate-limited step toward target, widened so it cannot wrap
    always_comb begin
        up_sum = {1'b0, duty} + STEP_W;
        dn_gap = {1'b0, duty} - {1'b0, target};
        slew   = duty;
        if (duty < target) begin
            if (up_sum >= {1'b0, target}) begin
                slew = target;
            end else begin
                slew = up_sum[SIZE-1:0];
            end
        end else if (duty > target) begin
            if (dn_gap <= STEP_W) begin
                slew = target;
            end else begin
                slew = duty - STEP_N;
            end
        end
    end

    // Duty only moves at the end of a PWM period while slewing
    always_comb begin
        slewing = (state == RAMP) || (state == REV_DOWN);
        duty_nx = duty;
        if (pwm_done && slewing) begin
            duty_nx = slew;
        end
    end

    // Handshake and status decode from the current state
    always_comb begin
        cmd_ready = 1'b0;
        unique case (state)
            IDLE, RAMP, HOLD: cmd_ready = !estop;
            default:          cmd_ready = 1'b0;
        endcase
        busy      = (state == RAMP) || (state == REV_DOWN)
                 || (state == DEAD);
        at_target = ((state == IDLE) || (state == HOLD))
                 && (duty == target);
    end

    // Accept qualification and dead-time terminal count
    always_comb begin
        accept    = cmd_valid && cmd_ready;
        same_dir  = (cmd_dir == dir)
                 || ((state == IDLE) && (duty == '0));
        dead_last = ({1'b0, dead_cnt} + (CW+1)'(1)) >= DEAD_W;
    end

    // Main sequencer: reset, then estop, then per-state behaviour
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            duty        <= '0;
            dir         <= 1'b0;
            target      <= '0;
            pend_target <= '0;
            pend_dir    <= 1'b0;
            dead_cnt    <= '0;
        end else if (estop) begin
            state       <= ESTOP;
            duty        <= '0;
            target      <= '0;
            pend_target <= '0;
            dead_cnt    <= '0;
        end else begin
            unique case (state)
                IDLE, RAMP, HOLD: begin
                    duty <= duty_nx;
                    if (accept) begin
                        if (same_dir) begin
                            target <= cmd_clamp;
                            dir    <= cmd_dir;
                            state  <= RAMP;
                        end else begin
                            pend_target <= cmd_clamp;
                            pend_dir    <= cmd_dir;
                            target      <= '0;
                            state       <= REV_DOWN;
                        end
                    end else if (state == RAMP) begin
                        if (duty_nx == target) begin
                            state <= HOLD;
                        end
                    end else if (state == HOLD) begin
                        if (target == '0) begin
                            state <= IDLE;
                        end
                    end
                end
                REV_DOWN: begin
                    duty <= duty_nx;
                    if (duty_nx == '0) begin
                        dead_cnt <= '0;
                        state    <= DEAD;
                    end
                end
                DEAD: begin
                    if (pwm_done) begin
                        if (dead_last) begin
                            dir    <= pend_dir;
                            target <= pend_target;
                            if (pend_target == '0) begin
                                state <= IDLE;
                            end else begin
                                state <= RAMP;
                            end
                        end else begin
                            dead_cnt <= dead_cnt + CW'(1);
                        end
                    end
                end
                ESTOP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: scoreboard bench for motor_ramp_ctrl.
// A rule-level model queues expected outputs; a monitor pops and compares.
module tb_motor_ramp_ctrl;

    localparam int SIZE   = 12;
    localparam int PERIOD = 100;
    localparam int STEP   = 10;
    localparam int DP     = 2;

    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_HOLD = 2;
    localparam int M_REV  = 3;
    localparam int M_DEAD = 4;
    localparam int M_EST  = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [SIZE-1:0] cmd_duty = '0;
    logic            cmd_dir = 1'b0;
    logic            estop = 1'b0;
    logic            pwm_done = 1'b0;
    logic [SIZE-1:0] duty;
    logic            dir;
    logic            busy;
    logic            at_target;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int duty;
        int dir;
        int rdy;
        int busy;
        int at;
    } exp_t;

    exp_t q[$];

    motor_ramp_ctrl #(
        .SIZE(SIZE),
        .PERIOD(PERIOD),
        .STEP(STEP),
        .DEAD_PERIODS(DP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_duty(cmd_duty),
        .cmd_dir(cmd_dir),
        .estop(estop),
        .pwm_done(pwm_done),
        .duty(duty),
        .dir(dir),
        .busy(busy),
        .at_target(at_target)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // reference model state
    int m_mode = M_IDLE;
    int m_duty = 0;
    int m_dir  = 0;
    int m_tgt  = 0;
    int m_ptgt = 0;
    int m_pdir = 0;
    int m_dead = 0;

    initial forever begin
        int   nd;
        int   c;
        bit   rdy;
        exp_t e;
        @(posedge clock);
        rdy = !estop && (m_mode == M_IDLE || m_mode == M_RAMP
                         || m_mode == M_HOLD);
        if (reset) begin
            m_mode = M_IDLE; m_duty = 0; m_dir = 0;
            m_tgt = 0; m_ptgt = 0; m_pdir = 0; m_dead = 0;
        end else if (estop) begin
            m_duty = 0; m_tgt = 0; m_mode = M_EST;
        end else begin
            nd = m_duty;
            if (pwm_done && (m_mode == M_RAMP || m_mode == M_REV)) begin
                if (m_duty < m_tgt)
                    nd = (m_duty + STEP > m_tgt) ? m_tgt : m_duty + STEP;
                else if (m_duty > m_tgt)
                    nd = (m_duty - STEP < m_tgt) ? m_tgt : m_duty - STEP;
            end
            case (m_mode)
                M_IDLE, M_RAMP, M_HOLD: begin
                    if (cmd_valid && rdy) begin
                        c = (int'(cmd_duty) > PERIOD) ? PERIOD : int'(cmd_duty);
                        if (int'(cmd_dir) == m_dir
                            || (m_mode == M_IDLE && m_duty == 0)) begin
                            m_tgt = c; m_dir = int'(cmd_dir); m_mode = M_RAMP;
                        end else begin
                            m_ptgt = c; m_pdir = int'(cmd_dir);
                            m_tgt = 0; m_mode = M_REV;
                        end
                    end else if (m_mode == M_RAMP && nd == m_tgt) begin
                        m_mode = M_HOLD;
                    end else if (m_mode == M_HOLD && m_tgt == 0) begin
                        m_mode = M_IDLE;
                    end
                    m_duty = nd;
                end
                M_REV: begin
                    m_duty = nd;
                    if (nd == 0) begin
                        m_mode = M_DEAD; m_dead = 0;
                    end
                end
                M_DEAD: begin
                    if (pwm_done) begin
                        m_dead++;
                        if (m_dead >= DP) begin
                            m_dir = m_pdir; m_tgt = m_ptgt;
                            m_mode = (m_ptgt == 0) ? M_IDLE : M_RAMP;
                        end
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        e.duty = m_duty;
        e.dir  = m_dir;
        e.rdy  = (!estop && (m_mode == M_IDLE || m_mode == M_RAMP
                             || m_mode == M_HOLD)) ? 1 : 0;
        e.busy = (m_mode == M_RAMP || m_mode == M_REV
                  || m_mode == M_DEAD) ? 1 : 0;
        e.at   = ((m_mode == M_IDLE || m_mode == M_HOLD)
                  && m_duty == m_tgt) ? 1 : 0;
        q.push_back(e);
    end

    // monitor: compares every cycle once outputs have settled
    initial begin
        int   pd;
        int   pdir;
        exp_t e;
        pd   = 0;
        pdir = 0;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() == 0) begin
                chk("sb_empty", 0, 1);
            end else begin
                e = q.pop_front();
                chk("sb_duty", int'(duty), e.duty);
                chk("sb_dir", int'(dir), e.dir);
                chk("sb_ready", int'(cmd_ready), e.rdy);
                chk("sb_busy", int'(busy), e.busy);
                chk("sb_at_target", int'(at_target), e.at);
            end
            chk("duty_le_period", int'(duty <= SIZE'(PERIOD)), 1);
            if (pd != 0 && !reset) begin
                chk("dir_stable_nonzero", int'(dir), pdir);
            end
            pd   = int'(duty);
            pdir = int'(dir);
        end
    end

    task automatic step(input bit pd);
        @(negedge clock);
        cmd_valid = 1'b0;
        pwm_done  = pd;
    endtask

    task automatic send(input int d, input bit dr, input bit pd);
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_duty  = SIZE'(d);
        cmd_dir   = dr;
        pwm_done  = pd;
    endtask

    task automatic pulse();
        step(1'b1);
        step(1'b0);
    endtask

    task automatic pulse_chk(input string nm, input int d);
        pulse();
        chk(nm, int'(duty), d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int est_left;
        reset = 1'b1;
        repeat (3) step(1'b0);
        reset = 1'b0;
        step(1'b0);
        chk("rst_duty", int'(duty), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_at_target", int'(at_target), 1);

        // soft start forward to 35
        send(35, 1'b0, 1'b0);
        step(1'b0);
        chk("s1_busy", int'(busy), 1);
        pulse_chk("s1_d10", 10);
        pulse_chk("s1_d20", 20);
        pulse_chk("s1_d30", 30);
        pulse_chk("s1_d35", 35);
        chk("s1_at_target", int'(at_target), 1);
        chk("s1_busy_lo", int'(busy), 0);

        // reversal through zero and dead time
        send(20, 1'b1, 1'b0);
        step(1'b0);
        chk("s2_ready_lo", int'(cmd_ready), 0);
        pulse_chk("s2_d25", 25);
        pulse_chk("s2_d15", 15);
        pulse_chk("s2_d5", 5);
        pulse_chk("s2_d0", 0);
        chk("s2_dir_held", int'(dir), 0);
        pulse();
        chk("s2_dead1_dir", int'(dir), 0);
        chk("s2_dead1_ready", int'(cmd_ready), 0);
        pulse();
        chk("s2_dead2_dir", int'(dir), 1);
        chk("s2_dead2_ready", int'(cmd_ready), 1);
        pulse_chk("s2_d10", 10);
        pulse_chk("s2_d20", 20);

        // oversize request clamps to PERIOD
        send(250, 1'b1, 1'b0);
        step(1'b0);
        repeat (8) pulse();
        chk("s3_d100", int'(duty), 100);
        chk("s3_at_target", int'(at_target), 1);
        pulse_chk("s3_d100_hold", 100);

        // back to zero, then estop mid ramp
        send(0, 1'b1, 1'b0);
        step(1'b0);
        repeat (10) pulse();
        step(1'b0);
        chk("s4_idle_d0", int'(duty), 0);
        send(60, 1'b1, 1'b0);
        step(1'b0);
        repeat (3) pulse();
        chk("s4_d30", int'(duty), 30);
        estop = 1'b1;
        step(1'b0);
        chk("s4_est_duty", int'(duty), 0);
        chk("s4_est_ready", int'(cmd_ready), 0);
        chk("s4_est_busy", int'(busy), 0);
        step(1'b0);
        estop = 1'b0;
        step(1'b0);
        chk("s4_exit_ready", int'(cmd_ready), 1);
        chk("s4_exit_dir", int'(dir), 1);

        // accept coincident with pwm_done uses old target
        send(50, 1'b1, 1'b0);
        step(1'b0);
        pulse_chk("s5_d10", 10);
        pulse_chk("s5_d20", 20);
        send(0, 1'b1, 1'b1);
        step(1'b0);
        chk("s5_d30", int'(duty), 30);
        pulse_chk("s5_d20b", 20);
        pulse_chk("s5_d10b", 10);
        pulse_chk("s5_d0", 0);
        step(1'b0);
        chk("s5_idle_at", int'(at_target), 1);
        chk("s5_idle_busy", int'(busy), 0);

        // reset during dead time discards the pending command
        send(20, 1'b1, 1'b0);
        step(1'b0);
        repeat (2) pulse();
        send(30, 1'b0, 1'b0);
        step(1'b0);
        repeat (2) pulse();
        pulse();
        chk("s6_dead_dir", int'(dir), 1);
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        chk("s6_rst_duty", int'(duty), 0);
        chk("s6_rst_dir", int'(dir), 0);
        chk("s6_rst_ready", int'(cmd_ready), 1);
        chk("s6_rst_busy", int'(busy), 0);
        repeat (3) pulse();
        chk("s6_no_pend", int'(duty), 0);
        chk("s6_no_pend_busy", int'(busy), 0);

        // randomized traffic against the model
        est_left = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            pwm_done  = ($urandom_range(0, 2) == 0);
            cmd_valid = ($urandom_range(0, 11) == 0);
            cmd_duty  = SIZE'($urandom_range(0, 160));
            cmd_dir   = 1'($urandom_range(0, 1));
            if (est_left > 0) begin
                est_left--;
            end else if ($urandom_range(0, 249) == 0) begin
                est_left = $urandom_range(1, 5);
            end
            estop = (est_left > 0);
            reset = ($urandom_range(0, 999) == 0);
        end
        step(1'b0);
        reset = 1'b0;
        estop = 1'b0;
        repeat (3) step(1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
